order_tx_framer: RTL and testbench

Serializes generated orders into a byte stream for the TX path. The block sits directly downstream of the scalar order generator: it captures each one-cycle `order_valid` pulse with its 32-bit `order_packet` into a small FIFO, then frames each order as a byte sequence on a valid/ready byte interface toward the MAC/UART stub. Orders arriving while the FIFO is full are dropped and counted.

---
 rtl/order_tx_framer_pkg.sv | 24 ++
 rtl/order_tx_framer_fifo.sv | 79 +++++++
 rtl/order_tx_framer.sv | 196 +++++++++++++++++++
 tb/tb_order_tx_framer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_tx_framer_pkg.sv
// order_tx_framer_pkg
// Shared definitions for the order TX framer:
//   - order opcodes carried in order_packet[31:16]
//   - default frame header byte
//   - framer FSM state encoding
//   - frame lengths in bytes, with and without the trailing checksum byte
package order_tx_framer_pkg;

  localparam logic [15:0] OPCODE_BUY  = 16'hB001;
  localparam logic [15:0] OPCODE_SELL = 16'hC001;

  localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

  localparam int FRAME_LEN_CKSUM   = 6;
  localparam int FRAME_LEN_NOCKSUM = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CKS  = 2'd3
  } state_t;

endpackage

// File: rtl/order_tx_framer_fifo.sv
// order_fifo
// Synchronous single-clock FIFO with a registered read port, so the
// storage maps onto block RAM. pop_data is loaded on the pop edge and then
// held until the next pop, which lets the consumer use it directly as the
// shadow copy of the popped word.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset (empties the FIFO)
//   push         write push_data (ignored while full)
//   push_data    word to write
//   pop          read the head into pop_data (ignored while empty)
//   pop_data     registered head word captured by the last pop
//   full, empty  occupancy flags, derived from the registered count
//   count        number of stored words
module order_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] pop_data_reg;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage has no reset so it can be implemented as RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_data_reg <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        pop_data_reg <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = pop_data_reg;
  assign count    = count_reg;

endmodule

// File: rtl/order_tx_framer.sv
// order_tx_framer
// Captures one-cycle order strobes into a small FIFO and serialises each
// order as a byte frame on a valid/ready byte interface:
//   HDR_BYTE, packet[31:24], [23:16], [15:8], [7:0] [, XOR of payload bytes]
// Orders that arrive while the FIFO is full are dropped and counted.
//
// Build option: define ORDER_TX_CKSUM_EN to append the checksum byte
// (6-byte frames, tx_last on the checksum). Without it frames are 5 bytes
// and tx_last marks payload byte 3.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   order_packet  32-bit order word, qualified by order_valid
//   order_valid   one-cycle strobe
//   tx_data       frame byte (registered)
//   tx_valid      tx_data is valid
//   tx_ready      consumer accepts the byte on tx_valid & tx_ready
//   tx_last       final byte of the frame
//   fifo_full     FIFO holds FIFO_DEPTH orders
//   drop_count    saturating count of orders dropped on a full FIFO
//   busy          a frame is in flight or orders are queued
module order_tx_framer
  import order_tx_framer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  HDR_BYTE   = DEFAULT_HDR_BYTE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  order_packet,
  input  logic         order_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         fifo_full,
  output logic [15:0]  drop_count,
  output logic         busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t      state_reg;
  logic [1:0]  idx_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_valid_reg;
  logic        tx_last_reg;
  logic [15:0] drop_count_reg;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full_int;
  logic [CW-1:0] fifo_count;
  logic [31:0]   shadow;

  logic        handshake;
  logic        frame_end;
  logic [1:0]  idx_next;
  logic [7:0]  pay_bytes [4];

  order_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (order_packet),
    .pop       (fifo_pop),
    .pop_data  (shadow),
    .full      (fifo_full_int),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Full is judged on occupancy at the start of the cycle, so a pop on the
  // same edge never makes room for a write.
  assign fifo_push = order_valid && !fifo_full_int;
  assign handshake = tx_valid_reg && tx_ready;
  assign idx_next  = idx_reg + 2'd1;

  // Payload byte gi of the captured order, most significant byte first.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pay
    assign pay_bytes[gi] = shadow[8*(3-gi) +: 8];
  end

`ifdef ORDER_TX_CKSUM_EN
  logic [7:0] cksum;
  assign cksum     = pay_bytes[0] ^ pay_bytes[1] ^ pay_bytes[2] ^ pay_bytes[3];
  assign frame_end = handshake && (state_reg == ST_CKS);
`else
  assign frame_end = handshake && (state_reg == ST_PAY) && (idx_reg == 2'd3);
`endif

  // The head is popped either when leaving IDLE or on the last-byte
  // handshake, so a queued frame starts with no idle gap.
  assign fifo_pop = !fifo_empty && ((state_reg == ST_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= 2'd0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      tx_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_reg    <= ST_HDR;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= HDR_BYTE;
            tx_last_reg  <= 1'b0;
          end
        end

        ST_HDR: begin
          if (handshake) begin
            state_reg   <= ST_PAY;
            idx_reg     <= 2'd0;
            tx_data_reg <= pay_bytes[0];
            tx_last_reg <= 1'b0;
          end
        end

        ST_PAY: begin
          if (handshake) begin
            if (idx_reg != 2'd3) begin
              idx_reg     <= idx_next;
              tx_data_reg <= pay_bytes[idx_next];
`ifdef ORDER_TX_CKSUM_EN
              tx_last_reg <= 1'b0;
`else
              tx_last_reg <= (idx_next == 2'd3);
`endif
            end else begin
`ifdef ORDER_TX_CKSUM_EN
              state_reg   <= ST_CKS;
              tx_data_reg <= cksum;
              tx_last_reg <= 1'b1;
`else
              // Last payload byte accepted: chain the next frame or idle.
              tx_last_reg <= 1'b0;
              if (!fifo_empty) begin
                state_reg   <= ST_HDR;
                tx_data_reg <= HDR_BYTE;
              end else begin
                state_reg    <= ST_IDLE;
                tx_valid_reg <= 1'b0;
              end
`endif
            end
          end
        end

`ifdef ORDER_TX_CKSUM_EN
        ST_CKS: begin
          if (handshake) begin
            tx_last_reg <= 1'b0;
            if (!fifo_empty) begin
              state_reg   <= ST_HDR;
              tx_data_reg <= HDR_BYTE;
            end else begin
              state_reg    <= ST_IDLE;
              tx_valid_reg <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state_reg    <= ST_IDLE;
          tx_valid_reg <= 1'b0;
          tx_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_reg <= 16'h0000;
    end else if (order_valid && fifo_full_int && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
  assign tx_last    = tx_last_reg;
  assign fifo_full  = fifo_full_int;
  assign drop_count = drop_count_reg;
  assign busy       = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_order_tx_framer.sv
// tb_order_tx_framer
// Scoreboard bench for order_tx_framer. Each accepted order pushes its
// expected frame bytes (built from the frame format with plain byte
// arithmetic) into a queue; a negedge monitor pops and compares on every
// handshake and checks that stalled bytes stay stable.
module tb_order_tx_framer;
  import order_tx_framer_pkg::*;

  localparam int DEPTH = 8;
`ifdef ORDER_TX_CKSUM_EN
  localparam int FLEN  = FRAME_LEN_CKSUM;
  localparam bit CKS   = 1'b1;
`else
  localparam int FLEN  = FRAME_LEN_NOCKSUM;
  localparam bit CKS   = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] order_packet;
  logic        order_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        fifo_full;
  logic [15:0] drop_count;
  logic        busy;

  order_tx_framer #(
    .FIFO_DEPTH (DEPTH),
    .HDR_BYTE   (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .order_packet (order_packet),
    .order_valid  (order_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_last      (tx_last),
    .fifo_full    (fifo_full),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q [$];   // {last, data}
  int issued = 0;
  int completed = 0;
  int ready_mode = 0;      // 0 low, 1 high, 2 random, 3 pattern 1,0,0,1
  logic [3:0] pat = 4'b1001;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference frame for one order.
  task automatic push_frame(input logic [31:0] pkt);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = pkt[31-8*i -: 8];
    exp_q.push_back({1'b0, 8'hA5});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) && !CKS, b[i]});
    if (CKS) exp_q.push_back({1'b1, b[0] ^ b[1] ^ b[2] ^ b[3]});
    issued++;
  endtask

  // Monitor / scoreboard.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(tx_valid), 32'd1);
          check("stall_data", 32'(tx_data), 32'(prev_data));
          check("stall_last", 32'(tx_last), 32'(prev_last));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%h required=none", tx_data);
          end else begin
            check("tx_data", 32'(tx_data), 32'(exp_q[0][7:0]));
            check("tx_last", 32'(tx_last), 32'(exp_q[0][8]));
            $display("byte data=%h last=%0d", tx_data, tx_last);
            void'(exp_q.pop_front());
            if (tx_last) completed++;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
    end
  end

  // tx_ready driver.
  initial begin
    int pidx;
    pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        2: tx_ready = ($urandom_range(0, 3) != 0);
        default: begin
          tx_ready = pat[pidx];
          pidx = (pidx + 1) % 4;
        end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pkt, input bit accept);
    order_packet = pkt;
    order_valid  = 1'b1;
    if (accept) push_frame(pkt);
    tick();
    order_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 3000), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    issued = completed;
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] pkt;
    rst = 1'b1;
    order_valid = 1'b0;
    order_packet = 32'h0;
    tx_ready = 1'b0;
    ready_mode = 0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;

    // Single BUY frame with latency check
    ready_mode = 1;
    tick();
    base = completed;
    send(32'hB0010010, 1'b1);
    @(negedge clk);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_valid_early", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_hdr_valid", 32'(tx_valid), 32'd1);
    check("lat_hdr_data", 32'(tx_data), 32'hA5);
    drain("drain_single");
    check("single_frames", 32'(completed - base), 32'd1);
    check("single_busy_low", 32'(busy), 32'd0);

    // Back-pressure SELL
    ready_mode = 3;
    send(32'hC0010005, 1'b1);
    drain("drain_backpressure");
    ready_mode = 1;
    tick();

    // Back-to-back frames
    send(32'hB0010020, 1'b1);
    send(32'hC0010030, 1'b1);
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_start", 32'(n < 10), 32'd1);
    for (int k = 0; k < 2 * FLEN; k++) begin
      check("b2b_no_gap", 32'(tx_valid), 32'd1);
      @(negedge clk);
    end
    check("b2b_busy_low", 32'(busy), 32'd0);
    check("b2b_valid_low", 32'(tx_valid), 32'd0);
    tick();

    // Overflow: one frame stalled in flight, then 10 back-to-back strobes
    ready_mode = 0;
    tick();
    tick();
    base = completed;
    send(32'hB0010001, 1'b1);
    repeat (3) tick();
    for (int i = 1; i <= 10; i++) begin
      pkt = 32'hC0010000 | 32'(i);
      order_packet = pkt;
      order_valid = 1'b1;
      if (i <= DEPTH) push_frame(pkt);
      tick();
      if (i == DEPTH - 1) check("ovf_not_full", 32'(fifo_full), 32'd0);
      if (i == DEPTH) check("ovf_full", 32'(fifo_full), 32'd1);
      if (i == DEPTH + 1) check("ovf_drop1", 32'(drop_count), 32'd1);
      if (i == 10) check("ovf_drop2", 32'(drop_count), 32'd2);
    end
    order_valid = 1'b0;
    ready_mode = 1;
    drain("drain_overflow");
    check("ovf_frames", 32'(completed - base), 32'(DEPTH + 1));
    check("ovf_full_clear", 32'(fifo_full), 32'd0);

    // Randomized traffic, never enough outstanding orders to fill the FIFO
    ready_mode = 2;
    for (int o = 0; o < 150; o++) begin
      n = 0;
      while ((issued - completed) >= DEPTH && n < 5000) begin
        tick();
        n++;
      end
      if (n >= 5000) check("rand_wait", 32'(n), 32'd0);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) != 0)
        pkt = {(($urandom_range(0, 1) != 0) ? OPCODE_BUY : OPCODE_SELL), 16'($urandom)};
      else
        pkt = $urandom;
      send(pkt, 1'b1);
    end
    drain("drain_random");
    check("rand_no_drops", 32'(drop_count), 32'd2);

    // Saturation of drop_count
    do_reset();
    ready_mode = 0;
    tick();
    tick();
    order_valid = 1'b1;
    for (int i = 1; i <= DEPTH + 1 + 65540; i++) begin
      pkt = {OPCODE_BUY, 16'(i)};
      order_packet = pkt;
      if (i <= DEPTH + 1) push_frame(pkt);
      tick();
      if (i == DEPTH + 1) begin
        check("sat_full", 32'(fifo_full), 32'd1);
        check("sat_drop0", 32'(drop_count), 32'd0);
      end
      if (i == DEPTH + 2) check("sat_drop1", 32'(drop_count), 32'd1);
      if (i == DEPTH + 1 + 65535) check("sat_reach", 32'(drop_count), 32'hFFFF);
      if (i == DEPTH + 1 + 65540) check("sat_hold", 32'(drop_count), 32'hFFFF);
    end
    order_valid = 1'b0;
    ready_mode = 1;
    drain("drain_saturation");
    check("sat_after_drain", 32'(drop_count), 32'hFFFF);

    // Reset mid-frame after byte B0
    send(32'hB0010010, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(tx_valid && tx_ready && tx_data == 8'hB0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_found_b0", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_fifo_full", 32'(fifo_full), 32'd0);
    check("mid_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    issued = completed;
    tick();
    base = completed;
    send(32'hC0010005, 1'b1);
    drain("drain_after_reset");
    check("mid_restart_frames", 32'(completed - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
